// File: rtl/l1_dcache_pkg.sv
// Shared types and helpers for the L1 data cache.
package l1_dcache_pkg;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StWriteback = 2'd1,
    StRefill    = 2'd2
  } cache_state_e;

  // Index width that stays legal for a single-entry dimension.
  function automatic int unsigned addr_bits(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/l1_dcache_data_ram.sv
// Line data store: asynchronous read, synchronous byte-enabled write, shared address.
module l1_dcache_data_ram #(
  parameter int unsigned Depth = 64,
  parameter int unsigned AddrW = 6
) (
  input  logic             clock,
  input  logic [AddrW-1:0] addr,
  output logic [31:0]      rdata,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [31:0]      wdata
);

  logic [31:0] mem [Depth];

  always_ff @(posedge clock) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/l1_dcache.sv
// Direct-mapped write-back, write-allocate L1 data cache with word-burst refill/writeback
// and saturating hit/miss counters.
module l1_dcache
  import l1_dcache_pkg::*;
#(
  parameter int unsigned LINES          = 16,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cpu_rd,
  input  logic             cpu_wr,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  input  logic [3:0]       cpu_be,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int unsigned IdxBits  = $clog2(LINES);
  localparam int unsigned WordBits = addr_bits(WORDS_PER_LINE);
  localparam int unsigned OffBits  = $clog2(WORDS_PER_LINE) + 2;
  localparam int unsigned TagBits  = 32 - IdxBits - OffBits;
  localparam int unsigned RamDepth = LINES * WORDS_PER_LINE;
  localparam int unsigned RamAw    = addr_bits(RamDepth);
  localparam logic [WordBits-1:0] LastWord = WordBits'(WORDS_PER_LINE - 1);

  cache_state_e        state_q;
  logic [WordBits-1:0] cnt_q;
  logic [LINES-1:0]    valid_q, dirty_q;
  logic [TagBits-1:0]  tag_q [LINES];
  logic [CNT_W-1:0]    hit_cnt_q, miss_cnt_q;

  logic [IdxBits-1:0]  idx;
  logic [TagBits-1:0]  tag, mem_tag;
  logic [WordBits-1:0] word, ram_word;
  logic                req, hit, last;
  logic [RamAw-1:0]    ram_addr;
  logic [31:0]         ram_rdata, ram_wdata;
  logic [3:0]          ram_be;
  logic                ram_we;

  assign idx  = IdxBits'(cpu_addr >> OffBits);
  assign tag  = cpu_addr[31 -: TagBits];
  assign word = WordBits'((cpu_addr >> 2) & (WORDS_PER_LINE - 1));
  assign req  = cpu_rd | cpu_wr;
  assign hit  = valid_q[idx] && (tag_q[idx] == tag);
  assign last = (cnt_q == LastWord);

  // In a burst the RAM port follows the word counter, otherwise the CPU offset.
  assign ram_word  = (state_q == StIdle) ? word : cnt_q;
  assign ram_addr  = RamAw'(32'(idx) * WORDS_PER_LINE + 32'(ram_word));
  assign ram_we    = (state_q == StIdle) ? (reset && cpu_wr && hit)
                                         : ((state_q == StRefill) && mem_ack);
  assign ram_be    = (state_q == StRefill) ? 4'hF : cpu_be;
  assign ram_wdata = (state_q == StRefill) ? mem_rdata : cpu_wdata;

  l1_dcache_data_ram #(
    .Depth (RamDepth),
    .AddrW (RamAw)
  ) u_data_ram (
    .clock (clock),
    .addr  (ram_addr),
    .rdata (ram_rdata),
    .we    (ram_we),
    .be    (ram_be),
    .wdata (ram_wdata)
  );

  // Reset forces the CPU-facing outputs low even while a request is presented.
  assign cpu_rdata = (reset && (state_q == StIdle) && cpu_rd && !cpu_wr && hit) ? ram_rdata
                                                                                 : '0;
  assign cpu_stall = reset && ((state_q != StIdle) || (req && !hit));

  assign mem_req   = (state_q != StIdle);
  assign mem_we    = (state_q == StWriteback);
  assign mem_tag   = (state_q == StWriteback) ? tag_q[idx] : tag;
  assign mem_addr  = mem_req ? ((32'(mem_tag) << (IdxBits + OffBits)) |
                                (32'(idx) << OffBits) | (32'(cnt_q) << 2)) : '0;
  assign mem_wdata = mem_we ? ram_rdata : '0;

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req) begin
            if (hit) begin
              if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
              if (cpu_wr) dirty_q[idx] <= 1'b1;
            end else begin
              if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
              cnt_q   <= '0;
              state_q <= (valid_q[idx] && dirty_q[idx]) ? StWriteback : StRefill;
            end
          end
        end
        StWriteback: begin
          if (mem_ack) begin
            if (last) begin
              cnt_q        <= '0;
              dirty_q[idx] <= 1'b0;
              state_q      <= StRefill;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StRefill: begin
          if (mem_ack) begin
            if (last) begin
              cnt_q        <= '0;
              valid_q[idx] <= 1'b1;
              dirty_q[idx] <= 1'b0;
              state_q      <= StIdle;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if ((state_q == StRefill) && mem_ack && last) tag_q[idx] <= tag;
  end

endmodule

// File: tb/tb_l1_dcache.sv
// Self-checking bench for l1_dcache: directed vectors, burst corner cases, randomized ops
// against a flat-memory / tag-table reference model.
module tb_l1_dcache;

  localparam int unsigned W = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [3:0]  cpu_be = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] hit_cnt, miss_cnt;

  l1_dcache #(
    .LINES          (16),
    .WORDS_PER_LINE (W),
    .CNT_W          (32)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_be    (cpu_be),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  always #5 clock = ~clock;

  // Backing memory with a programmable number of wait cycles before each ack.
  logic [31:0] backing [16384];
  int unsigned mem_wait = 0;
  int unsigned wcnt = 0;
  int unsigned ack_cnt = 0;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;
  xfer_t log_q[$];

  function automatic logic [31:0] init_word(int unsigned w);
    return 32'hAAAA0000 + w - 32'd64;
  endfunction

  always @(negedge clock) begin
    if (!reset || !mem_req) begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end else if (wcnt >= mem_wait) begin
      mem_ack   = 1'b1;
      wcnt      = 0;
      mem_rdata = backing[mem_addr[15:2]];
    end else begin
      mem_ack = 1'b0;
      wcnt++;
    end
  end

  always @(posedge clock) begin
    if (reset && mem_req && mem_ack) begin
      ack_cnt++;
      if (mem_we) begin
        backing[mem_addr[15:2]] = mem_wdata;
        log_q.push_back('{1'b1, mem_addr, mem_wdata});
      end else begin
        log_q.push_back('{1'b0, mem_addr, mem_rdata});
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // Presents one request (caller sits just after a rising edge) and holds it until the
  // stall drops; reports the load data, stall cycles and burst observations.
  task automatic cpu_op(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output logic [31:0] rdata, output int stalls,
                        output int first_req, output bit saw_we);
    bit done;
    cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata; cpu_be = be;
    stalls = 0; first_req = -1; saw_we = 0; done = 0; rdata = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      if (mem_req && first_req < 0) first_req = c;
      if (mem_req && mem_we) saw_we = 1;
      if (!cpu_stall) begin
        rdata = cpu_rdata;
        done  = 1;
        break;
      end
      stalls++;
    end
    check("op_completes", {31'd0, done}, 32'd1);
    @(posedge clock);
    #1;
    cpu_rd = 1'b0; cpu_wr = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  typedef struct {
    logic        rd, wr;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    int          exp_stalls, exp_nwr, exp_nrd;
  } vec_t;
  vec_t vecs[8];

  logic [31:0] ref_mem [16384];
  bit          ref_valid [16];
  bit          ref_dirty [16];
  int unsigned ref_tag [16];

  initial begin
    logic [31:0] rdata;
    int          stalls, first_req, lb, nwr, nrd, base;
    bit          saw_we;
    logic [31:0] wb_exp [4];

    for (int i = 0; i < 16384; i++) backing[i] = init_word(i);

    repeat (2) @(posedge clock);
    #1;
    check("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_hit_cnt", hit_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;

    //         rd    wr    addr        wdata         be     rdata         stall wr rd
    vecs[0] = '{1'b1, 1'b0, 32'h100, 32'h0,        4'h0, 32'hAAAA0000, 5, 0, 4};
    vecs[1] = '{1'b1, 1'b0, 32'h104, 32'h0,        4'h0, 32'hAAAA0001, 0, 0, 0};
    vecs[2] = '{1'b0, 1'b1, 32'h108, 32'h55,       4'h1, 32'h0,        0, 0, 0};
    vecs[3] = '{1'b1, 1'b0, 32'h108, 32'h0,        4'h0, 32'hAAAA0055, 0, 0, 0};
    vecs[4] = '{1'b0, 1'b1, 32'h214, 32'hDEADBEEF, 4'hF, 32'h0,        5, 0, 4};
    vecs[5] = '{1'b1, 1'b0, 32'h214, 32'h0,        4'h0, 32'hDEADBEEF, 0, 0, 0};
    vecs[6] = '{1'b1, 1'b1, 32'h218, 32'h0000BEEF, 4'h3, 32'h0,        0, 0, 0};
    vecs[7] = '{1'b1, 1'b0, 32'h218, 32'h0,        4'h0, 32'hAAAABEEF, 0, 0, 0};

    for (int v = 0; v < 8; v++) begin
      lb = log_q.size();
      cpu_op(vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].be,
             rdata, stalls, first_req, saw_we);
      nwr = 0; nrd = 0;
      for (int i = lb; i < log_q.size(); i++) begin
        if (log_q[i].we) nwr++; else nrd++;
      end
      check($sformatf("vec%0d_rdata", v), rdata, vecs[v].exp_rdata);
      check($sformatf("vec%0d_stalls", v), stalls, vecs[v].exp_stalls);
      check($sformatf("vec%0d_nwr", v), nwr, vecs[v].exp_nwr);
      check($sformatf("vec%0d_nrd", v), nrd, vecs[v].exp_nrd);
      if (v == 0) begin
        for (int i = 0; i < 4; i++)
          check($sformatf("cold_rd_addr%0d", i), log_q[lb+i].addr, 32'h100 + 4*i);
      end
    end
    check("vec_miss_cnt", miss_cnt, 32'd2);
    check("vec_hit_cnt", hit_cnt, 32'd8);

    // Dirty eviction: writeback of the old line, then refill of the new one.
    wb_exp[0] = 32'hAAAA0000; wb_exp[1] = 32'hAAAA0001;
    wb_exp[2] = 32'hAAAA0055; wb_exp[3] = 32'hAAAA0003;
    lb = log_q.size();
    cpu_op(1'b1, 1'b0, 32'h1100, 32'h0, 4'h0, rdata, stalls, first_req, saw_we);
    check("dirty_stalls", stalls, 9);
    check("dirty_rdata", rdata, 32'hAAAA0400);
    check("dirty_nxfer", log_q.size() - lb, 8);
    if (log_q.size() - lb >= 8) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("wb%0d_we", i), {31'd0, log_q[lb+i].we}, 32'd1);
        check($sformatf("wb%0d_addr", i), log_q[lb+i].addr, 32'h100 + 4*i);
        check($sformatf("wb%0d_data", i), log_q[lb+i].data, wb_exp[i]);
        check($sformatf("rf%0d_we", i), {31'd0, log_q[lb+4+i].we}, 32'd0);
        check($sformatf("rf%0d_addr", i), log_q[lb+4+i].addr, 32'h1100 + 4*i);
      end
    end

    // Clean eviction: no writeback, refill begins the cycle after the miss.
    cpu_op(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, rdata, stalls, first_req, saw_we);
    check("clean_stalls", stalls, 5);
    check("clean_saw_we", {31'd0, saw_we}, 32'd0);
    check("clean_first_req", first_req, 1);
    check("clean_rdata", rdata, 32'hAAAA0000);

    // Slow memory: three wait cycles before every ack.
    mem_wait = 3;
    cpu_op(1'b1, 1'b0, 32'h1100, 32'h0, 4'h0, rdata, stalls, first_req, saw_we);
    check("slow_stalls", stalls, 17);
    check("slow_rdata", rdata, 32'hAAAA0400);
    check("slow_miss_cnt", miss_cnt, 32'd5);
    check("slow_hit_cnt", hit_cnt, 32'd11);

    // Reset in the middle of a refill, after two words have landed.
    base = ack_cnt;
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h300;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (ack_cnt - base >= 2) break;
    end
    check("midrst_acks", ack_cnt - base, 32'd2);
    #1 reset = 1'b0;
    #1;
    check("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    check("midrst_stall", {31'd0, cpu_stall}, 32'd0);
    check("midrst_hit_cnt", hit_cnt, 32'd0);
    check("midrst_miss_cnt", miss_cnt, 32'd0);
    cpu_rd = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    mem_wait = 0;
    cpu_op(1'b1, 1'b0, 32'h104, 32'h0, 4'h0, rdata, stalls, first_req, saw_we);
    check("postrst_stalls", stalls, 5);
    check("postrst_rdata", rdata, 32'hAAAA0001);
    check("postrst_miss_cnt", miss_cnt, 32'd1);
    check("postrst_hit_cnt", hit_cnt, 32'd1);

    // Randomized traffic against a flat memory plus a tag table.
    do_reset();
    for (int i = 0; i < 16384; i++) ref_mem[i] = backing[i];
    for (int i = 0; i < 16; i++) begin
      ref_valid[i] = 0; ref_dirty[i] = 0; ref_tag[i] = 0;
    end
    begin
      int unsigned exp_hit, exp_miss, op, idx, tg, widx, exp_stalls;
      logic [31:0] addr, wdata, exp_rd;
      logic [3:0]  be;
      logic        rd, wr;
      bit          m_hit;
      exp_hit = 0; exp_miss = 0;
      for (int n = 0; n < 300; n++) begin
        op    = $urandom_range(0, 2);
        rd    = (op != 1);
        wr    = (op != 0);
        addr  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 4) |
                ($urandom_range(0, 3) << 2);
        wdata = $urandom;
        be    = 4'($urandom_range(0, 15));
        mem_wait = ($urandom_range(0, 1) != 0) ? 3 : 0;
        widx  = addr >> 2;
        idx   = (addr >> 4) & 15;
        tg    = addr >> 8;
        m_hit = ref_valid[idx] && (ref_tag[idx] == tg);
        exp_stalls = m_hit ? 0 : 1 + W * (mem_wait + 1) * ((ref_valid[idx] && ref_dirty[idx]) ? 2 : 1);
        if (!m_hit) begin
          exp_miss++;
          ref_dirty[idx] = 0;
        end
        exp_hit++;
        ref_valid[idx] = 1;
        ref_tag[idx]   = tg;
        if (wr) begin
          ref_dirty[idx] = 1;
          for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[widx][8*b +: 8] = wdata[8*b +: 8];
          exp_rd = '0;
        end else begin
          exp_rd = ref_mem[widx];
        end
        cpu_op(rd, wr, addr, wdata, be, rdata, stalls, first_req, saw_we);
        check($sformatf("rnd%0d_rdata", n), rdata, exp_rd);
        check($sformatf("rnd%0d_stalls", n), stalls, exp_stalls);
      end
      check("rnd_hit_cnt", hit_cnt, exp_hit);
      check("rnd_miss_cnt", miss_cnt, exp_miss);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
